// File: rtl/boot_loader.sv
// Streams a length-prefixed program into memory and then releases the CPU; writes land one cycle after accept.
// Backpressure: rx_ready is high only while waiting for the header or program words, so no data is ever dropped.
module boot_loader #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned HOLD_CYCLES = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [15:0] rx_data,
    input  logic        start,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_din,
    output logic        preload_active,
    output logic        cpu_reset,
    output logic        done,
    output logic        len_err,
    output logic [8:0]  words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LEN,
        LOAD,
        FLUSH,
        HOLD,
        RUN,
        ERR
    } stateT;

    localparam logic [7:0]  HOLD_INIT = 8'(HOLD_CYCLES - 1);
    localparam logic [15:0] MAX_LEN   = 16'd256;

    stateT       state;
    stateT       nextState;
    logic [7:0]  wrPtr;
    logic [8:0]  remaining;
    logic [7:0]  holdCnt;
    logic        xfer;
    logic        loadWord;
    logic        enterWaitLen;
    logic        enterHold;

    assign rx_ready     = (state == WAIT_LEN) || (state == LOAD);
    assign xfer         = rx_valid && rx_ready;
    assign loadWord     = xfer && (state == LOAD);
    assign enterWaitLen = (nextState == WAIT_LEN) && (state != WAIT_LEN);
    assign enterHold    = (nextState == HOLD) && (state != HOLD);

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: nextState = WAIT_LEN;
            WAIT_LEN: begin
                if (xfer) begin
                    if (rx_data == 16'd0) begin
                        nextState = HOLD;
                    end else if (rx_data > MAX_LEN) begin
                        nextState = ERR;
                    end else begin
                        nextState = LOAD;
                    end
                end
            end
            // The last accepted word still has its write pending, hence FLUSH.
            LOAD: begin
                if (xfer && (remaining == 9'd1)) begin
                    nextState = FLUSH;
                end
            end
            FLUSH: nextState = HOLD;
            HOLD: begin
                if (holdCnt == 8'd0) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (start) begin
                    nextState = WAIT_LEN;
                end
            end
            ERR:     nextState = ERR;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            wrPtr          <= BASE_ADDR;
            remaining      <= 9'd0;
            holdCnt        <= 8'd0;
            mem_we         <= 1'b0;
            mem_addr       <= BASE_ADDR;
            mem_din        <= 16'd0;
            preload_active <= 1'b1;
            cpu_reset      <= 1'b1;
            done           <= 1'b0;
            len_err        <= 1'b0;
            words_loaded   <= 9'd0;
        end else begin
            state  <= nextState;
            mem_we <= loadWord;

            if (loadWord) begin
                mem_addr     <= wrPtr;
                mem_din      <= rx_data;
                wrPtr        <= wrPtr + 8'd1;
                remaining    <= remaining - 9'd1;
                words_loaded <= words_loaded + 9'd1;
            end

            if ((state == WAIT_LEN) && xfer) begin
                remaining <= rx_data[8:0];
            end

            // Every fresh load, including a reload from RUN, restarts at BASE_ADDR.
            if (enterWaitLen) begin
                wrPtr        <= BASE_ADDR;
                words_loaded <= 9'd0;
            end

            if (enterHold) begin
                holdCnt <= HOLD_INIT;
            end else if ((state == HOLD) && (holdCnt != 8'd0)) begin
                holdCnt <= holdCnt - 8'd1;
            end

            // Status outputs are registered from the next state so they track state exactly.
            preload_active <= (nextState == IDLE) || (nextState == WAIT_LEN) ||
                              (nextState == LOAD) || (nextState == FLUSH);
            cpu_reset      <= (nextState != RUN);
            done           <= (nextState == RUN);
            len_err        <= (nextState == ERR);
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a default instance plus a BASE_ADDR=8'hFE instance sharing stimulus.
module tb_boot_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rxValid = 1'b0;
    logic [15:0] rxData = 16'd0;
    logic        start = 1'b0;

    logic        rxReady, memWe, preloadActive, cpuReset, done, lenErr;
    logic [7:0]  memAddr;
    logic [15:0] memDin;
    logic [8:0]  wordsLoaded;

    logic        rxReadyHi, memWeHi, preloadActiveHi, cpuResetHi, doneHi, lenErrHi;
    logic [7:0]  memAddrHi;
    logic [15:0] memDinHi;
    logic [8:0]  wordsLoadedHi;

    logic [5:0]  flags;
    logic [23:0] wrLog[$];
    logic [23:0] wrLogHi[$];

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    assign flags = {rxReady, memWe, preloadActive, cpuReset, done, lenErr};

    boot_loader dut (
        .clock(clock), .reset(reset), .rx_valid(rxValid), .rx_data(rxData), .start(start),
        .rx_ready(rxReady), .mem_we(memWe), .mem_addr(memAddr), .mem_din(memDin),
        .preload_active(preloadActive), .cpu_reset(cpuReset), .done(done),
        .len_err(lenErr), .words_loaded(wordsLoaded)
    );

    boot_loader #(.BASE_ADDR(8'hFE)) dutHi (
        .clock(clock), .reset(reset), .rx_valid(rxValid), .rx_data(rxData), .start(start),
        .rx_ready(rxReadyHi), .mem_we(memWeHi), .mem_addr(memAddrHi), .mem_din(memDinHi),
        .preload_active(preloadActiveHi), .cpu_reset(cpuResetHi), .done(doneHi),
        .len_err(lenErrHi), .words_loaded(wordsLoadedHi)
    );

    always @(negedge clock) begin
        if (memWe === 1'b1) wrLog.push_back({memAddr, memDin});
        if (memWeHi === 1'b1) wrLogHi.push_back({memAddrHi, memDinHi});
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; rxValid = 1'b1; rxData = 16'h0005; start = 1'b1;
        tick(); tick();
        checks++;
        if ({flags, memAddr, memDin, wordsLoaded} !== {6'b001100, 8'h00, 16'h0000, 9'd0}) begin
            failures++;
            $display("FAIL reset_values got=%b/%h/%h/%0d exp=001100/00/0000/0", flags, memAddr, memDin, wordsLoaded);
        end
        checks++;
        if (memAddrHi !== 8'hFE) begin
            failures++;
            $display("FAIL reset_base_addr got=%h exp=fe", memAddrHi);
        end
        reset = 1'b0; rxValid = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (flags !== 6'b101100) begin
            failures++;
            $display("FAIL idle_to_wait_len got=%b exp=101100", flags);
        end
    endtask

    task automatic test_basic_load;
        wrLog.delete(); wrLogHi.delete();
        rxValid = 1'b1; rxData = 16'd3;
        tick();
        checks++;
        if (flags !== 6'b101100) begin
            failures++;
            $display("FAIL basic_header got=%b exp=101100", flags);
        end
        rxData = 16'hA001;
        tick();
        checks++;
        if ({memWe, memAddr, memDin, wordsLoaded} !== {1'b1, 8'h00, 16'hA001, 9'd1}) begin
            failures++;
            $display("FAIL basic_first_write got=%b/%h/%h/%0d exp=1/00/a001/1", memWe, memAddr, memDin, wordsLoaded);
        end
        rxData = 16'hA002;
        tick();
        rxData = 16'hA003;
        tick();
        checks++;
        if ({flags, memAddr, memDin, wordsLoaded} !== {6'b011100, 8'h02, 16'hA003, 9'd3}) begin
            failures++;
            $display("FAIL basic_flush got=%b/%h/%h/%0d exp=011100/02/a003/3", flags, memAddr, memDin, wordsLoaded);
        end
        rxValid = 1'b0; rxData = 16'h5555;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if ({flags, memAddr, memDin} !== {6'b000100, 8'h02, 16'hA003}) begin
                failures++;
                $display("FAIL basic_hold_%0d got=%b/%h/%h exp=000100/02/a003", i, flags, memAddr, memDin);
            end
        end
        tick();
        checks++;
        if ({flags, wordsLoaded} !== {6'b000010, 9'd3}) begin
            failures++;
            $display("FAIL basic_run got=%b/%0d exp=000010/3", flags, wordsLoaded);
        end
        checks++;
        if (wrLog.size() != 3 || wrLog[0] !== {8'h00, 16'hA001} ||
            wrLog[1] !== {8'h01, 16'hA002} || wrLog[2] !== {8'h02, 16'hA003}) begin
            failures++;
            $display("FAIL basic_write_log got_count=%0d exp_count=3 (00:a001 01:a002 02:a003)", wrLog.size());
        end
        rxValid = 1'b1; rxData = 16'h1234;
        tick(); tick();
        rxValid = 1'b0;
        checks++;
        if (flags !== 6'b000010 || wrLog.size() != 3) begin
            failures++;
            $display("FAIL run_ignores_rx got=%b/%0d exp=000010/3", flags, wrLog.size());
        end
    endtask

    task automatic test_base_wrap;
        checks++;
        if (wrLogHi.size() != 3 || wrLogHi[0] !== {8'hFE, 16'hA001} ||
            wrLogHi[1] !== {8'hFF, 16'hA002} || wrLogHi[2] !== {8'h00, 16'hA003}) begin
            failures++;
            $display("FAIL base_wrap_log got_count=%0d exp_count=3 (fe:a001 ff:a002 00:a003)", wrLogHi.size());
        end
    endtask

    task automatic test_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({flags, wordsLoaded} !== {6'b101100, 9'd0}) begin
            failures++;
            $display("FAIL start_reload got=%b/%0d exp=101100/0", flags, wordsLoaded);
        end
    endtask

    task automatic test_zero_len;
        wrLog.delete();
        rxValid = 1'b1; rxData = 16'd0;
        tick();
        rxValid = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            checks++;
            if (flags !== 6'b000100) begin
                failures++;
                $display("FAIL zero_hold_%0d got=%b exp=000100", i, flags);
            end
            tick();
        end
        checks++;
        if ({flags, wordsLoaded} !== {6'b000010, 9'd0} || wrLog.size() != 0) begin
            failures++;
            $display("FAIL zero_run got=%b/%0d writes=%0d exp=000010/0 writes=0", flags, wordsLoaded, wrLog.size());
        end
        test_start();
    endtask

    task automatic test_toggle_valid;
        int n;
        wrLog.delete();
        rxValid = 1'b1; rxData = 16'd4;
        tick();
        for (int k = 0; k < 4; k++) begin
            rxValid = 1'b0; rxData = 16'hDEAD;
            tick();
            checks++;
            if (memWe !== 1'b0) begin
                failures++;
                $display("FAIL toggle_idle_%0d got_we=%b exp_we=0", k, memWe);
            end
            rxValid = 1'b1; rxData = 16'hC000 + 16'(k);
            tick();
            checks++;
            if ({memWe, memAddr, memDin} !== {1'b1, k[7:0], 16'hC000 + 16'(k)}) begin
                failures++;
                $display("FAIL toggle_write_%0d got=%b/%h/%h exp=1/%h/%h", k, memWe, memAddr, memDin, k[7:0], 16'hC000 + 16'(k));
            end
        end
        rxValid = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 || wordsLoaded !== 9'd4 || wrLog.size() != 4) begin
            failures++;
            $display("FAIL toggle_done got=%b/%0d writes=%0d exp=1/4 writes=4", done, wordsLoaded, wrLog.size());
        end
        test_start();
    endtask

    task automatic test_len_boundary;
        rxValid = 1'b1; rxData = 16'h0100;
        tick();
        rxValid = 1'b0;
        checks++;
        if (flags !== 6'b101100) begin
            failures++;
            $display("FAIL len_256_accepted got=%b exp=101100", flags);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_len_err;
        wrLog.delete();
        rxValid = 1'b1; rxData = 16'h0101;
        tick();
        checks++;
        if (flags !== 6'b000101) begin
            failures++;
            $display("FAIL len_err_enter got=%b exp=000101", flags);
        end
        start = 1'b1; rxData = 16'h0002;
        tick(); tick(); tick();
        checks++;
        if (flags !== 6'b000101 || wrLog.size() != 0) begin
            failures++;
            $display("FAIL len_err_sticky got=%b writes=%0d exp=000101 writes=0", flags, wrLog.size());
        end
        start = 1'b0; rxValid = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if (flags !== 6'b001100) begin
            failures++;
            $display("FAIL len_err_reset got=%b exp=001100", flags);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort;
        int n;
        wrLog.delete();
        rxValid = 1'b1; rxData = 16'd5;
        tick();
        rxData = 16'h1111;
        tick();
        rxData = 16'h2222;
        tick();
        checks++;
        if ({memWe, memAddr, memDin, wordsLoaded} !== {1'b1, 8'h01, 16'h2222, 9'd2}) begin
            failures++;
            $display("FAIL abort_second_write got=%b/%h/%h/%0d exp=1/01/2222/2", memWe, memAddr, memDin, wordsLoaded);
        end
        reset = 1'b1; rxData = 16'h3333; start = 1'b1;
        tick();
        checks++;
        if ({flags, memAddr, memDin, wordsLoaded} !== {6'b001100, 8'h00, 16'h0000, 9'd0}) begin
            failures++;
            $display("FAIL abort_reset_values got=%b/%h/%h/%0d exp=001100/00/0000/0", flags, memAddr, memDin, wordsLoaded);
        end
        tick();
        reset = 1'b0; rxValid = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (wrLog.size() != 2) begin
            failures++;
            $display("FAIL abort_write_count got=%0d exp=2", wrLog.size());
        end
        rxValid = 1'b1; rxData = 16'd1;
        tick();
        rxData = 16'hBEEF;
        tick();
        rxValid = 1'b0;
        checks++;
        if ({memWe, memAddr, memDin} !== {1'b1, 8'h00, 16'hBEEF}) begin
            failures++;
            $display("FAIL reload_write got=%b/%h/%h exp=1/00/beef", memWe, memAddr, memDin);
        end
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1 || cpuReset !== 1'b0) begin
            failures++;
            $display("FAIL reload_run got_done=%b got_cpu_reset=%b exp=1/0", done, cpuReset);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({rxReady, cpuReset, done} !== 3'b110) begin
            failures++;
            $display("FAIL reload_start got=%b exp=110", {rxReady, cpuReset, done});
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_base_wrap();
        test_start();
        test_zero_len();
        test_toggle_valid();
        test_len_boundary();
        test_len_err();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter BASE_ADDR, default 8'h00, first memory address written.
REQ-002 Parameter HOLD_CYCLES, default 7, number of cycles CPU reset is held after load completes (legal range 1..255).
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_valid  input  1  upstream word available.
REQ-006 rx_data  input  16  upstream word (length header, then program words).
REQ-007 start  input  1  single-cycle request to reload; honoured only in RUN.
REQ-008 rx_ready  output  1  loader can accept rx_data this cycle.
REQ-009 mem_we  output  1  memory write-enable pulse.
REQ-010 mem_addr  output  8  memory write address.
REQ-011 mem_din  output  16  memory write data.
REQ-012 preload_active  output  1  memory address/data/we mux select (1 = loader owns memory port).
REQ-013 cpu_reset  output  1  reset to processor, active-high.
REQ-014 done  output  1  program loaded and CPU running.
REQ-015 len_err  output  1  header length exceeded 256.
REQ-016 words_loaded  output  9  count of program words written this load.

Function
REQ-017 States: IDLE, WAIT_LEN, LOAD, FLUSH, HOLD, RUN, ERR; all outputs registered except rx_ready, which SHALL decode from state only.
REQ-018 IDLE SHALL move to WAIT_LEN unconditionally on the next cycle.
REQ-019 rx_ready SHALL be 1 exactly in WAIT_LEN and LOAD; a transfer occurs on a cycle with rx_valid & rx_ready.
REQ-020 WAIT_LEN transfer: length L = rx_data; L==0 -> HOLD; 1<=L<=256 -> LOAD with remaining=L; L>256 -> ERR.
REQ-021 LOAD transfer: next cycle mem_we=1, mem_din=accepted word, mem_addr=current write pointer; pointer then increments modulo 256 (8'hFF wraps to 8'h00).
REQ-022 mem_we SHALL be a one-cycle pulse per accepted program word; back-to-back transfers yield back-to-back pulses at consecutive addresses.
REQ-023 Write latency from accept to mem_we SHALL be exactly one cycle.
REQ-024 words_loaded SHALL increment with each mem_we pulse and equal L after the final write.
REQ-025 Transfer of the L-th word SHALL move LOAD -> FLUSH; FLUSH issues the final mem_we pulse, then -> HOLD.
REQ-026 preload_active SHALL be 1 in IDLE, WAIT_LEN, LOAD, FLUSH and 0 in HOLD, RUN, ERR.
REQ-027 cpu_reset SHALL be 1 in every state except RUN.
REQ-028 HOLD SHALL last exactly HOLD_CYCLES cycles, then -> RUN.
REQ-029 RUN: cpu_reset=0, done=1; stays in RUN until start.
REQ-030 start in RUN SHALL, next cycle, enter WAIT_LEN with cpu_reset=1, done=0, preload_active=1, write pointer=BASE_ADDR, words_loaded=0; start in other states ignored.
REQ-031 rx_valid with rx_ready=0 SHALL not be consumed and SHALL cause no memory write.
REQ-032 ERR: len_err=1, cpu_reset=1, rx_ready=0, no writes; exits only via reset.
REQ-033 mem_addr and mem_din SHALL hold their last values when mem_we=0.

Reset
REQ-034 reset high SHALL win over all other inputs, including start and rx_valid, and abort any load in progress with no further mem_we.
REQ-035 Reset values: state IDLE, rx_ready 0, mem_we 0, mem_addr BASE_ADDR, mem_din 0, preload_active 1, cpu_reset 1, done 0, len_err 0, words_loaded 0.

Verification
REQ-036 Reset, then stream 3, 16'hA001, 16'hA002, 16'hA003 with rx_valid held -> writes to 0x00..0x02, words_loaded=3, cpu_reset low exactly 7 cycles after FLUSH, done=1.
REQ-037 Header 0 -> no mem_we, HOLD 7 cycles, RUN with done=1, words_loaded=0.
REQ-038 BASE_ADDR=8'hFE, header 3 -> writes at 0xFE, 0xFF, 0x00.
REQ-039 Header 16'h0101 -> ERR, len_err=1, rx_ready=0, cpu_reset=1, no mem_we; reset clears len_err.
REQ-040 rx_valid toggled every other cycle during header 4 -> exactly 4 mem_we pulses, data in order, none on idle cycles.
REQ-041 Reset asserted after 2 of 5 words -> mem_we stops, outputs at reset values; reload of header 1, 16'hBEEF writes 16'hBEEF to BASE_ADDR; then start in RUN -> cpu_reset=1, done=0, rx_ready=1 next cycle.
